// File: rtl/k_and_s_pkg.sv
// k_and_s_pkg: types and constants shared by the K&S control unit and datapath.
//   decoded_instruction_type : opcode class produced by the datapath decoder
//   ctrl_state_t             : control FSM state encoding
//   ctrl_out_t               : bundle of control strobes driven by the FSM
//   ALU_ADD/SUB/OR/AND       : ALU operation select codes
//   alu_op()                 : ALU operation for an ALU-class instruction
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_LOAD   = 4'd1,
        I_STORE  = 4'd2,
        I_MOVE   = 4'd3,
        I_ADD    = 4'd4,
        I_SUB    = 4'd5,
        I_AND    = 4'd6,
        I_OR     = 4'd7,
        I_BRANCH = 4'd8,
        I_BZERO  = 4'd9,
        I_BNZERO = 4'd10,
        I_BNEG   = 4'd11,
        I_BNNEG  = 4'd12,
        I_HALT   = 4'd13
    } decoded_instruction_type;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        FETCH_W   = 4'd1,
        DECODE    = 4'd2,
        LOAD_A    = 4'd3,
        LOAD_W    = 4'd4,
        STORE_A   = 4'd5,
        STORE_W   = 4'd6,
        ALU       = 4'd7,
        BR        = 4'd8,
        HALTED    = 4'd9,
        STEP_WAIT = 4'd10
    } ctrl_state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b11;

    typedef struct packed {
        logic       branch;
        logic       pc_enable;
        logic       ir_enable;
        logic       addr_sel;
        logic       c_sel;
        logic [1:0] operation;
        logic       write_reg_enable;
        logic       flags_reg_enable;
        logic       ram_write_enable;
        logic       halt;
    } ctrl_out_t;

    // MOVE is executed as OR with B forced to zero by the datapath.
    function automatic logic [1:0] alu_op(input decoded_instruction_type instr);
        case (instr)
            I_ADD:   alu_op = ALU_ADD;
            I_SUB:   alu_op = ALU_SUB;
            I_AND:   alu_op = ALU_AND;
            default: alu_op = ALU_OR;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_branch_cond.sv
// branch_cond: combinational branch-taken evaluator.
//   instr_i : decoded instruction class
//   zero_i  : registered zero flag
//   neg_i   : registered negative flag
//   taken_o : 1 when instr_i is a branch whose condition holds (0 for non-branches)
module branch_cond
    import k_and_s_pkg::*;
(
    input  decoded_instruction_type instr_i,
    input  logic                    zero_i,
    input  logic                    neg_i,
    output logic                    taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (instr_i)
            I_BRANCH: taken_o = 1'b1;
            I_BZERO:  taken_o = zero_i;
            I_BNZERO: taken_o = ~zero_i;
            I_BNEG:   taken_o = neg_i;
            I_BNNEG:  taken_o = ~neg_i;
            default:  taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle Moore FSM sequencing the K&S datapath
// (fetch, decode, execute, writeback).
//   clk, rst_n          : clock, asynchronous active-low reset
//   decoded_instruction : opcode class from the datapath
//   zero_op, neg_op     : registered flags from the datapath
//   branch, pc_enable   : PC source select / PC update strobe
//   ir_enable           : instruction register load
//   addr_sel, c_sel     : RAM address source / C-bus source
//   operation           : ALU op (00 ADD, 01 SUB, 10 OR, 11 AND)
//   write_reg_enable, flags_reg_enable, ram_write_enable : write strobes
//   halt                : processor halted
// Parameter RAM_RD_LAT (1 or 2): RAM read wait states before IR load and LOAD capture.
// Optional macro KS_SINGLE_STEP_EN adds step_req/step_wait: each finished
// instruction parks in STEP_WAIT until a rising edge of step_req.
module control_unit
    import k_and_s_pkg::*;
#(
    parameter int unsigned RAM_RD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt
`ifdef KS_SINGLE_STEP_EN
    ,
    input  logic                    step_req,
    output logic                    step_wait
`endif
);

    localparam logic [1:0] LatLast = 2'(RAM_RD_LAT - 1);

`ifdef KS_SINGLE_STEP_EN
    localparam ctrl_state_t DoneState = STEP_WAIT;
`else
    localparam ctrl_state_t DoneState = FETCH;
`endif

    ctrl_state_t             state_q, state_d;
    decoded_instruction_type instr_q, instr_d;
    logic                    taken_q, taken_d;
    logic [1:0]              wait_q, wait_d;
    logic                    taken;
    ctrl_out_t               out_raw, out_gated;

    branch_cond u_branch_cond (
        .instr_i (decoded_instruction),
        .zero_i  (zero_op),
        .neg_i   (neg_op),
        .taken_o (taken)
    );

`ifdef KS_SINGLE_STEP_EN
    logic step_q;
    logic step_wait_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) step_q <= 1'b0;
        else        step_q <= step_req;
    end
`endif

    // Next state. The instruction class and branch outcome are captured in
    // DECODE so that execute-state outputs depend on registers only.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        taken_d = taken_q;
        wait_d  = 2'd0;
        case (state_q)
            FETCH:   state_d = (RAM_RD_LAT > 1) ? FETCH_W : DECODE;
            FETCH_W: state_d = DECODE;
            DECODE: begin
                instr_d = decoded_instruction;
                taken_d = taken;
                case (decoded_instruction)
                    I_LOAD:                                        state_d = LOAD_A;
                    I_STORE:                                       state_d = STORE_A;
                    I_MOVE, I_ADD, I_SUB, I_AND, I_OR:             state_d = ALU;
                    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG:  state_d = BR;
                    I_HALT:                                        state_d = HALTED;
                    default:                                       state_d = DoneState;
                endcase
            end
            LOAD_A: begin
                if (wait_q == LatLast) state_d = LOAD_W;
                else                   wait_d  = wait_q + 2'd1;
            end
            LOAD_W:  state_d = DoneState;
            STORE_A: state_d = STORE_W;
            STORE_W: state_d = DoneState;
            ALU:     state_d = DoneState;
            BR:      state_d = DoneState;
            HALTED:  state_d = HALTED;
`ifdef KS_SINGLE_STEP_EN
            STEP_WAIT: if (step_req && !step_q) state_d = FETCH;
`endif
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            instr_q <= I_NOP;
            taken_q <= 1'b0;
            wait_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            taken_q <= taken_d;
            wait_q  <= wait_d;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        out_raw = '0;
        case (state_q)
            FETCH:   out_raw.ir_enable = (RAM_RD_LAT == 1);
            FETCH_W: out_raw.ir_enable = 1'b1;
            DECODE:  out_raw.pc_enable = 1'b1;
            LOAD_A:  out_raw.addr_sel  = 1'b1;
            LOAD_W: begin
                out_raw.addr_sel         = 1'b1;
                out_raw.c_sel            = 1'b1;
                out_raw.write_reg_enable = 1'b1;
            end
            STORE_A: out_raw.addr_sel = 1'b1;
            STORE_W: begin
                out_raw.addr_sel         = 1'b1;
                out_raw.ram_write_enable = 1'b1;
            end
            ALU: begin
                out_raw.write_reg_enable = 1'b1;
                out_raw.operation        = alu_op(instr_q);
                out_raw.flags_reg_enable = (instr_q != I_MOVE);
            end
            BR: begin
                out_raw.branch    = taken_q;
                out_raw.pc_enable = taken_q;
            end
            HALTED:  out_raw.halt = 1'b1;
            default: out_raw = '0;
        endcase
    end

    // FETCH already asserts ir_enable with a 1-cycle RAM, so the reset level
    // masks the strobes to keep everything quiet while reset is held.
    assign out_gated = rst_n ? out_raw : '0;

    assign branch           = out_gated.branch;
    assign pc_enable        = out_gated.pc_enable;
    assign ir_enable        = out_gated.ir_enable;
    assign addr_sel         = out_gated.addr_sel;
    assign c_sel            = out_gated.c_sel;
    assign operation        = out_gated.operation;
    assign write_reg_enable = out_gated.write_reg_enable;
    assign flags_reg_enable = out_gated.flags_reg_enable;
    assign ram_write_enable = out_gated.ram_write_enable;
    assign halt             = out_gated.halt;

`ifdef KS_SINGLE_STEP_EN
    assign step_wait_raw = (state_q == STEP_WAIT);
    assign step_wait     = rst_n & step_wait_raw;
`endif

endmodule
